// File: rtl/updown_counter_tick_param.sv
// -----------------------------------------------------------------------------
// updown_counter_tick_param
//
// Purpose:
//   WIDTH-bit up/down counter that steps on an internally generated tick.
//   The tick comes from a prescaler on the single system clock (no derived
//   clock) and runs at SLOW_HZ or FAST_HZ. End-of-range behaviour is wrap,
//   saturate or bounce. There is a synchronous load and a terminal-count
//   pulse. All outputs are registered.
//
// Ports:
//   Clk50MHz  in   1      system clock, rising edge
//   RST       in   1      asynchronous active-high reset
//   SS        in   1      1 = run, 0 = pause (prescaler, count, DIR hold)
//   UD        in   1      1 = up, 0 = down (bounce mode: sampled on LOAD only)
//   SPEED     in   1      0 = SLOW_HZ, 1 = FAST_HZ
//   MODE      in   2      00/11 = wrap, 01 = saturate, 10 = bounce
//   LOAD      in   1      synchronous load strobe
//   LOAD_VAL  in   WIDTH  value loaded on LOAD
//   CNT_OUT   out  WIDTH  current count
//   TICK      out  1      one-cycle pulse on every step edge
//   TC        out  1      one-cycle pulse when a step hits a range boundary
//   DIR       out  1      effective direction, 1 = up
// -----------------------------------------------------------------------------
module updown_counter_tick_param #(
    parameter int WIDTH   = 8,
    parameter int CLK_HZ  = 50000000,
    parameter int SLOW_HZ = 1,
    parameter int FAST_HZ = 5
) (
    input  logic             Clk50MHz,
    input  logic             RST,
    input  logic             SS,
    input  logic             UD,
    input  logic             SPEED,
    input  logic [1:0]       MODE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] CNT_OUT,
    output logic             TICK,
    output logic             TC,
    output logic             DIR
);

    localparam int DIV_S   = CLK_HZ / SLOW_HZ;
    localparam int DIV_F   = CLK_HZ / FAST_HZ;
    localparam int DIV_MAX = (DIV_S > DIV_F) ? DIV_S : DIV_F;
    localparam int PW      = $clog2(DIV_MAX);

    localparam logic [PW-1:0]    LAST_S  = PW'(DIV_S - 1);
    localparam logic [PW-1:0]    LAST_F  = PW'(DIV_F - 1);
    localparam logic [PW-1:0]    P_ONE   = PW'(1);
    localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    localparam logic [1:0] MODE_SAT    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    logic [WIDTH-1:0] r_cnt;
    logic [PW-1:0]    r_presc;
    logic             r_tick;
    logic             r_tc;
    logic             r_dir;
    logic             r_speed_q;

    logic             w_bounce;
    logic             w_up;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_presc_last;
    logic             w_speed_chg;
    logic [WIDTH-1:0] w_step_cnt;
    logic             w_step_tc;
    logic             w_step_dir;

    // Next count / TC / DIR for a step edge. Wrap relies on natural
    // modulo-2^WIDTH overflow of the increment and decrement.
    always_comb begin
        w_bounce     = (MODE == MODE_BOUNCE);
        w_up         = w_bounce ? r_dir : UD;
        w_at_max     = (r_cnt == CNT_MAX);
        w_at_min     = (r_cnt == '0);
        w_presc_last = (r_presc == (SPEED ? LAST_F : LAST_S));
        w_speed_chg  = (SPEED != r_speed_q);

        w_step_cnt   = w_up ? (r_cnt + C_ONE) : (r_cnt - C_ONE);
        w_step_tc    = 1'b0;
        w_step_dir   = w_bounce ? r_dir : UD;

        case (MODE)
            MODE_SAT: begin
                // Pinned at a boundary: hold and repeat TC on every tick.
                if ((w_up && w_at_max) || (!w_up && w_at_min)) begin
                    w_step_cnt = r_cnt;
                    w_step_tc  = 1'b1;
                end
            end
            MODE_BOUNCE: begin
                // Reverse at the end so the boundary value is not repeated.
                if (r_dir && w_at_max) begin
                    w_step_cnt = CNT_MAX - C_ONE;
                    w_step_dir = 1'b0;
                    w_step_tc  = 1'b1;
                end else if (!r_dir && w_at_min) begin
                    w_step_cnt = C_ONE;
                    w_step_dir = 1'b1;
                    w_step_tc  = 1'b1;
                end
            end
            default: begin
                w_step_tc = (w_up && w_at_max) || (!w_up && w_at_min);
            end
        endcase
    end

    // Priority: RST > LOAD > SPEED change > step. Outside bounce mode DIR
    // tracks UD on every running cycle; during pause it holds.
    always_ff @(posedge Clk50MHz or posedge RST) begin
        if (RST) begin
            r_cnt     <= '0;
            r_presc   <= '0;
            r_tick    <= 1'b0;
            r_tc      <= 1'b0;
            r_dir     <= 1'b1;
            r_speed_q <= 1'b0;
        end else begin
            r_speed_q <= SPEED;
            if (LOAD) begin
                r_cnt   <= LOAD_VAL;
                r_presc <= '0;
                r_dir   <= UD;
                r_tick  <= 1'b0;
                r_tc    <= 1'b0;
            end else if (w_speed_chg) begin
                // Restart the period at the new rate; no step this cycle.
                r_presc <= '0;
                r_tick  <= 1'b0;
                r_tc    <= 1'b0;
                if (SS && !w_bounce) begin
                    r_dir <= UD;
                end
            end else if (SS) begin
                if (w_presc_last) begin
                    r_presc <= '0;
                    r_tick  <= 1'b1;
                    r_cnt   <= w_step_cnt;
                    r_tc    <= w_step_tc;
                    r_dir   <= w_step_dir;
                end else begin
                    r_presc <= r_presc + P_ONE;
                    r_tick  <= 1'b0;
                    r_tc    <= 1'b0;
                    if (!w_bounce) begin
                        r_dir <= UD;
                    end
                end
            end else begin
                r_tick <= 1'b0;
                r_tc   <= 1'b0;
            end
        end
    end

    assign CNT_OUT = r_cnt;
    assign TICK    = r_tick;
    assign TC      = r_tc;
    assign DIR     = r_dir;

endmodule

// File: tb/tb_updown_counter_tick_param.sv
module tb_updown_counter_tick_param;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ss;
    logic             ud;
    logic             speed;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt_out;
    logic             tick;
    logic             tc;
    logic             dir;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    // Expected step: cycle number of the tick plus count, TC and DIR after it.
    typedef struct packed {
        logic [31:0]      cyc;
        logic [WIDTH-1:0] cnt;
        logic             tc;
        logic             dir;
    } exp_t;
    exp_t exp_q[$];

    updown_counter_tick_param #(
        .WIDTH  (WIDTH),
        .CLK_HZ (20),
        .SLOW_HZ(1),
        .FAST_HZ(5)
    ) dut (
        .Clk50MHz(clk),
        .RST     (rst),
        .SS      (ss),
        .UD      (ud),
        .SPEED   (speed),
        .MODE    (mode),
        .LOAD    (load),
        .LOAD_VAL(load_val),
        .CNT_OUT (cnt_out),
        .TICK    (tick),
        .TC      (tc),
        .DIR     (dir)
    );

    // ---------------- clock / cycle counter ----------------
    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_tick(input int c, input int cnt, input logic t, input logic d);
        exp_t e;
        e.cyc = 32'(c);
        e.cnt = WIDTH'(cnt);
        e.tc  = t;
        e.dir = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("tc_without_tick", 32'(tc && !tick), 32'd0);
            if (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_tick: no tick seen, expected at cycle %0d (now %0d)",
                         exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (tick === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tick: tick at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("tick_cycle", 32'(cyc), e.cyc);
                    check("tick_cnt", 32'(cnt_out), 32'(e.cnt));
                    check("tick_tc", 32'(tc), 32'(e.tc));
                    check("tick_dir", 32'(dir), 32'(e.dir));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int c;
    int t;

    initial begin
        rst      = 1'b1;
        ss       = 1'b0;
        ud       = 1'b1;
        speed    = 1'b0;
        mode     = 2'b00;
        load     = 1'b0;
        load_val = '0;
        repeat (3) @(negedge clk);
        check("reset_cnt", 32'(cnt_out), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_tc", 32'(tc), 32'd0);
        check("reset_dir", 32'(dir), 32'd1);

        // T1: wrap up at the slow rate, first tick on edge 20.
        rst = 1'b0;
        ss  = 1'b1;
        c   = cyc;
        for (int k = 1; k <= 16; k++) push_tick(c + 20 * k, k % 16, k == 16, 1'b1);
        wait_until(c + 320);

        // T2: fast rate, then back to slow mid-period with prescaler at 2.
        speed = 1'b1;
        c     = cyc;
        push_tick(c + 5, 1, 1'b0, 1'b1);
        push_tick(c + 9, 2, 1'b0, 1'b1);
        push_tick(c + 13, 3, 1'b0, 1'b1);
        wait_until(c + 15);
        speed = 1'b0;
        push_tick(c + 36, 4, 1'b0, 1'b1);
        wait_until(c + 36);

        // T3: saturate at max, then at zero.
        mode     = 2'b01;
        load_val = 4'd14;
        ud       = 1'b1;
        load     = 1'b1;
        c        = cyc;
        @(negedge clk);
        load = 1'b0;
        check("sat_load_cnt", 32'(cnt_out), 32'd14);
        check("sat_load_tick", 32'(tick), 32'd0);
        push_tick(c + 21, 15, 1'b0, 1'b1);
        push_tick(c + 41, 15, 1'b1, 1'b1);
        push_tick(c + 61, 15, 1'b1, 1'b1);
        wait_until(c + 61);
        load_val = 4'd0;
        ud       = 1'b0;
        load     = 1'b1;
        c        = cyc;
        @(negedge clk);
        load = 1'b0;
        check("sat_load0_cnt", 32'(cnt_out), 32'd0);
        check("sat_load0_dir", 32'(dir), 32'd0);
        push_tick(c + 21, 0, 1'b1, 1'b0);
        push_tick(c + 41, 0, 1'b1, 1'b0);
        wait_until(c + 41);

        // T4: bounce from 14 upward; UD toggles must be ignored.
        mode     = 2'b10;
        load_val = 4'd14;
        ud       = 1'b1;
        load     = 1'b1;
        c        = cyc;
        @(negedge clk);
        load = 1'b0;
        ud   = 1'b0;
        check("bnc_load_dir", 32'(dir), 32'd1);
        push_tick(c + 21, 15, 1'b0, 1'b1);
        for (int k = 2; k <= 16; k++) push_tick(c + 1 + 20 * k, 16 - k, k == 2, 1'b0);
        push_tick(c + 341, 1, 1'b1, 1'b1);
        wait_until(c + 150);
        ud = 1'b1;
        wait_until(c + 250);
        ud = 1'b0;
        wait_until(c + 341);

        // T5: pause with prescaler at 7 for 50 cycles, then resume.
        mode = 2'b00;
        ud   = 1'b1;
        c    = cyc;
        wait_until(c + 7);
        ss = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (k % 10 == 0) begin
                check("pause_cnt", 32'(cnt_out), 32'd1);
                check("pause_dir", 32'(dir), 32'd1);
            end
            check("pause_tick", 32'(tick), 32'd0);
        end
        ss = 1'b1;
        push_tick(c + 70, 2, 1'b0, 1'b1);
        wait_until(c + 70);

        // T6: LOAD coinciding with the tick edge, then async reset.
        t = cyc;
        wait_until(t + 19);
        load_val = 4'd9;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("ld_tick_cnt", 32'(cnt_out), 32'd9);
        check("ld_tick_tick", 32'(tick), 32'd0);
        check("ld_tick_tc", 32'(tc), 32'd0);
        push_tick(t + 40, 10, 1'b0, 1'b1);
        wait_until(t + 40);
        ud = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_dir", 32'(dir), 32'd0);
        check("pre_rst_cnt", 32'(cnt_out), 32'd10);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_cnt", 32'(cnt_out), 32'd0);
        check("async_rst_dir", 32'(dir), 32'd1);
        check("async_rst_tick", 32'(tick), 32'd0);
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_counter_tick_param.md
Name: updown_counter_tick_param

Overview:
- Parametrised successor to the fixed 8-bit, 1 Hz/5 Hz up/down counter.
- Generates its own step-enable tick from the single system clock, with no derived clock, selectable between two rates.
- Drives a WIDTH-bit counter with wrap, saturate or bounce end-of-range modes, synchronous load, and a terminal-count pulse.
- Sits directly between the board clock, the switches and the LED bank.

Parameters:
- WIDTH, 8, counter width in bits; 2..32.
- CLK_HZ, 50000000, Clk50MHz frequency in Hz.
- SLOW_HZ, 1, step rate when SPEED=0; DIV_S = CLK_HZ/SLOW_HZ, must be >= 2.
- FAST_HZ, 5, step rate when SPEED=1; DIV_F = CLK_HZ/FAST_HZ, must be >= 2.

Ports:
- Clk50MHz  in  1  system clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- SS  in  1  1 = run, 0 = pause (prescaler and count hold).
- UD  in  1  1 = count up, 0 = count down; in bounce mode, sampled only on LOAD.
- SPEED  in  1  0 = SLOW_HZ, 1 = FAST_HZ.
- MODE  in  2  00 = wrap, 01 = saturate, 10 = bounce, 11 = wrap.
- LOAD  in  1  synchronous load strobe.
- LOAD_VAL  in  WIDTH  value loaded on LOAD.
- CNT_OUT  out  WIDTH  current count.
- TICK  out  1  one-cycle pulse on every step edge.
- TC  out  1  one-cycle pulse when a step hits a range boundary.
- DIR  out  1  effective direction; 1 = up.

Behaviour:
- Reset (RST=1, asynchronous): CNT_OUT=0, TICK=0, TC=0, DIR=1, prescaler=0, speed_q=0. Everything holds while RST=1.
- Divisor: DIV = SPEED ? DIV_F : DIV_S. The prescaler width is ceil(log2(max(DIV_S,DIV_F))).
- Speed change: speed_q registers SPEED every cycle. On any cycle where SPEED != speed_q:
  - prescaler <= 0;
  - no step occurs that cycle.
- Run (SS=1):
  - If prescaler == DIV-1: prescaler <= 0, TICK <= 1, and the count steps on that same edge. CNT_OUT and TICK change together, so the period is exactly DIV cycles.
  - Otherwise: prescaler increments and TICK <= 0.
  - The first TICK after reset with SS=1 is registered on the DIV-th rising edge.
- Pause (SS=0): prescaler, CNT_OUT and DIR hold; TICK=0; TC=0. On resume the prescaler continues from its held value, so the remaining part of the period completes.
- TC: is 0 on every cycle that is not a step edge.
- Step, wrap mode (MODE=00/11):
  - CNT <= CNT±1 mod 2^WIDTH.
  - TC <= 1 when going max→0 (up) or 0→max (down).
  - DIR follows UD every cycle.
- Step, saturate mode (MODE=01):
  - At max going up, or at 0 going down: CNT holds and TC <= 1. TC repeats on every tick while pinned.
  - Otherwise CNT±1.
  - DIR follows UD.
- Step, bounce mode (MODE=10):
  - Direction comes from the internal DIR register, not UD.
  - At max with DIR=1: CNT <= max-1, DIR <= 0, TC <= 1.
  - At 0 with DIR=0: CNT <= 1, DIR <= 1, TC <= 1.
  - Otherwise CNT±1 per DIR.
  - When entering bounce mode, DIR keeps its last value.
- LOAD: highest priority below RST. Effective regardless of SS.
  - CNT <= LOAD_VAL, prescaler <= 0, DIR <= UD.
  - TICK <= 0 and TC <= 0 that cycle.
  - A tick coinciding with LOAD is discarded.
- Priority order: RST > LOAD > SPEED change > step.
- MODE change takes effect at the next step. No other state is cleared.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Benches use CLK_HZ=20, SLOW_HZ=1, FAST_HZ=5 (DIV_S=20, DIV_F=4) and WIDTH=4.
- T1, wrap up: RST pulse, then SS=1, UD=1, SPEED=0, MODE=00. Required: TICK high 1 cycle every 20 cycles, first on edge 20; CNT 0→1→…→15→0. TC=1 only on the 15→0 step.
- T2, speed switch: SS=1, SPEED=1. Required: period 4. Set SPEED=0 mid-period (prescaler=2). Required: no tick that cycle, then the next TICK exactly 20 cycles after the prescaler is cleared.
- T3, saturate: MODE=01, LOAD with LOAD_VAL=14, UD=1. Required: 15, then 15, 15 with TC=1 on each pinned tick. Then LOAD with LOAD_VAL=0, UD=0. Required: holds 0, TC pulses each tick.
- T4, bounce: MODE=10, LOAD with LOAD_VAL=14, UD=1. Required: 15 (TC=0), 14 (TC=1, DIR=0), 13 … 0, then 1 (TC=1, DIR=1). Toggling UD has no effect.
- T5, pause: SS=0 when prescaler=7. Required: CNT, DIR and prescaler frozen for 50 cycles, TICK=0. Set SS=1. Required: next TICK after 13 more cycles.
- T6, LOAD on tick edge and async reset: assert LOAD with LOAD_VAL=9 on the tick cycle. Required: CNT=9, TICK=0, next tick 20 cycles later. Assert RST between edges. Required: CNT_OUT=0 and DIR=1 immediately, with no clock edge needed.
